mips16_single_cycle: RTL and testbench
======================================

Name: mips16_single_cycle

Overview:
- Tiny Tapeout top-level wrapper around a 16-bit single-cycle MIPS-style CPU.
- Contains an on-chip 16x16 instruction memory loaded byte-wise through the pins, an 8x16 register file and an 8x16 data memory.
- A debug mux shows registers, the PC or instruction-memory contents on uo_out.
- One instruction retires per enabled clock.

Parameters:
- none. Fixed sizes: IMEM 16 words, DMEM 8 words, 8 registers, PC 4 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  when 0, hold all state (no PC, register, memory or IMEM writes).
- ui_in  in  8  bit 7 = prog_en. Prog mode: [3:0] IMEM addr, [4] byte select (0 = low, 1 = high), [5] write strobe. Run mode: [2:0] register select, [3] show PC, [4] byte select.
- uo_out  out  8  debug byte (see Behaviour).
- uio_in  in  8  programming data byte.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all bidirectionals are inputs).

Behaviour:
- Reset (rst_n = 0 at a clock edge) clears PC, all registers, DMEM and IMEM; uo_out then reads 0x00.
- An all-zero IMEM word decodes as ADD r0,r0,r0, i.e. a NOP.
- Prog mode (prog_en = 1, ena = 1):
  - PC is forced to 0; no register or DMEM writes occur.
  - If ui_in[5] = 1, the byte ui_in[4] of IMEM[ui_in[3:0]] is written with uio_in.
  - uo_out = byte ui_in[4] of IMEM[ui_in[3:0]], combinational readback.
- Run mode (prog_en = 0, ena = 1): each clock executes the instruction at IMEM[PC].
- uo_out in run mode:
  - ui_in[3] = 1: {4'b0, PC}.
  - Otherwise: byte ui_in[4] of register ui_in[2:0].
  - Combinational from current state.
- Formats:
  - R-type: op[15:12] rs[11:9] rt[8:6] rd[5:3] fn[2:0].
  - I-type: op rs rt imm6[5:0], sign-extended.
  - LLI: op rd[11:9] imm9[8:0], zero-extended.
  - J: op tgt[11:0], low 4 bits used.
- Opcodes:
  - 0 R-type, by fn: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1 or 0), 6 SLL rd = rs << rt[3:0], 7 SRL (logical).
  - 1 ADDI: rt = rs + imm.
  - 2 SLTI: rt = (rs < imm) signed.
  - 3 LW: rt = DMEM[(rs + imm)[2:0]].
  - 4 SW: DMEM[(rs + imm)[2:0]] = rt.
  - 5 BEQ, 6 BNE: if taken, PC = PC + 1 + imm, else PC + 1.
  - 7 J: PC = tgt[3:0].
  - 8 LLI: rd = imm9.
  - 9 to 15: NOP.
- Arithmetic wraps modulo 2^16. PC arithmetic wraps modulo 16, so 15 + 1 = 0.
- r0 always reads 0; writes to it are discarded.
- Register-file and DMEM writes and the PC update occur on the same edge. Reads are combinational, so a read-after-write in the next instruction sees the new value.
- Reset takes priority over ena and prog_en. Reset asserted mid-program returns PC to 0 and clears IMEM; the program must be reloaded.
- ena = 0 freezes everything; uo_out still tracks the selects.

Decomposition:
- Package mips16_pkg holds:
  - opcode localparams (OP_RTYPE = 0 through OP_LLI = 8);
  - fn codes;
  - field-position constants;
  - widths (data 16, register address 3, PC 4).
- One sub-module is natural: mips16_alu, combinational, taking a, b and fn and returning y.
- Register file, memories, decode and debug mux live in the top.

Test Plan:
- Reset: hold rst_n = 0 for 2 clocks, run mode, ui_in = 0x08 -> uo_out = 0x00. ui_in = 0x01 -> uo_out = 0x00.
- Load/readback: prog mode, write IMEM[0] = 0x8205 (two byte writes). Then set addr 0 with byte select 1, strobe 0 -> uo_out = 0x82; with byte select 0 -> 0x05.
- ALU program: IMEM = 0x8205 (LLI r1,5), 0x8407 (LLI r2,7), 0x0298 (ADD r3,r1,r2), 0x02A1 (SUB r4,r1,r2). Run 4 clocks:
  - reg 3 low byte -> 0x0C;
  - reg 4 high byte -> 0xFF, low byte -> 0xFE;
  - PC -> 0x04.
- Memory: append 0x40C2 (SW r3,2(r0)) and 0x3142 (LW r5,2(r0)) -> after 6 clocks, reg 5 low byte = 0x0C.
- Branch and freeze: IMEM[6] = 0x503F (BEQ r0,r0,-1) -> PC stays 0x06 on every later clock. Holding ena = 0 with the PC at 2 for 5 clocks -> PC stays 2.
- r0 and J: 0x8011 (LLI r0,0x11) then 0x700A (J 10) -> r0 reads 0x00 and PC = 0x0A.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared constants for the 16-bit single-cycle MIPS-style core.
// Includes opcodes, ALU function codes, instruction field positions and widths.
package mips16_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_AW     = 3;
  localparam int PC_W       = 4;
  localparam int NUM_REGS   = 8;
  localparam int IMEM_DEPTH = 16;
  localparam int DMEM_DEPTH = 8;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_SLTI  = 4'd2;
  localparam logic [3:0] OP_LW    = 4'd3;
  localparam logic [3:0] OP_SW    = 4'd4;
  localparam logic [3:0] OP_BEQ   = 4'd5;
  localparam logic [3:0] OP_BNE   = 4'd6;
  localparam logic [3:0] OP_J     = 4'd7;
  localparam logic [3:0] OP_LLI   = 4'd8;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_SLT = 3'd5;
  localparam logic [2:0] FN_SLL = 3'd6;
  localparam logic [2:0] FN_SRL = 3'd7;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RS_MSB   = 11;
  localparam int RS_LSB   = 9;
  localparam int RT_MSB   = 8;
  localparam int RT_LSB   = 6;
  localparam int RD_MSB   = 5;
  localparam int RD_LSB   = 3;
  localparam int FN_MSB   = 2;
  localparam int FN_LSB   = 0;
  localparam int IMM6_MSB = 5;
  localparam int IMM9_MSB = 8;

  function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
    return {{(DATA_W-6){v[5]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext9(input logic [8:0] v);
    return {{(DATA_W-9){1'b0}}, v};
  endfunction

endpackage

// File: rtl/mips16_alu.sv
// Combinational 16-bit ALU shared by R-type, immediate and address arithmetic.
module mips16_alu
  import mips16_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        fn,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (fn)
      FN_ADD: y = a + b;
      FN_SUB: y = a - b;
      FN_AND: y = a & b;
      FN_OR:  y = a | b;
      FN_XOR: y = a ^ b;
      FN_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLL: y = a << b[3:0];
      FN_SRL: y = a >> b[3:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mips16_single_cycle.sv
// Tiny Tapeout wrapper: pin-loaded instruction memory, single-cycle core,
// register file, data memory and a debug byte mux on uo_out.
module mips16_single_cycle
  import mips16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [DATA_W-1:0] imem_reg [IMEM_DEPTH];
  logic [DATA_W-1:0] rf_reg   [NUM_REGS];
  logic [DATA_W-1:0] dmem_reg [DMEM_DEPTH];
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   pc_plus1;

  logic              prog_en;
  logic              prog_we;
  logic              byte_sel;
  logic [3:0]        prog_addr;
  logic              unused_ui6;

  logic [DATA_W-1:0] instr;
  logic [3:0]        op;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [2:0]        fn;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_fn;
  logic [DATA_W-1:0] alu_y;

  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              dm_we;
  logic [2:0]        dm_addr;
  logic [DATA_W-1:0] dbg_word;

  assign prog_en    = ui_in[7];
  assign prog_we    = ui_in[5];
  assign byte_sel   = ui_in[4];
  assign prog_addr  = ui_in[3:0];
  assign unused_ui6 = ui_in[6];

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign instr   = imem_reg[pc_reg];
  assign op      = instr[OP_MSB:OP_LSB];
  assign rs      = instr[RS_MSB:RS_LSB];
  assign rt      = instr[RT_MSB:RT_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign fn      = instr[FN_MSB:FN_LSB];
  assign imm_ext = sext6(instr[IMM6_MSB:0]);
  assign rs_val  = rf_reg[rs];
  assign rt_val  = rf_reg[rt];
  assign pc_plus1 = pc_reg + 4'd1;

  mips16_alu u_alu (
    .a  (rs_val),
    .b  (alu_b),
    .fn (alu_fn),
    .y  (alu_y)
  );

  // Memory addresses reuse the ALU adder; only the low 3 bits index DMEM.
  assign dm_addr = alu_y[2:0];

  always_comb begin
    alu_b   = rt_val;
    alu_fn  = fn;
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = alu_y;
    dm_we   = 1'b0;
    pc_next = pc_plus1;
    case (op)
      OP_RTYPE: wr_en = 1'b1;
      OP_ADDI: begin
        alu_b = imm_ext; alu_fn = FN_ADD; wr_en = 1'b1; wr_addr = rt;
      end
      OP_SLTI: begin
        alu_b = imm_ext; alu_fn = FN_SLT; wr_en = 1'b1; wr_addr = rt;
      end
      OP_LW: begin
        alu_b = imm_ext; alu_fn = FN_ADD; wr_en = 1'b1; wr_addr = rt;
        wr_data = dmem_reg[dm_addr];
      end
      OP_SW: begin
        alu_b = imm_ext; alu_fn = FN_ADD; dm_we = 1'b1;
      end
      OP_BEQ: if (rs_val == rt_val) pc_next = pc_plus1 + imm_ext[PC_W-1:0];
      OP_BNE: if (rs_val != rt_val) pc_next = pc_plus1 + imm_ext[PC_W-1:0];
      OP_J:   pc_next = instr[PC_W-1:0];
      OP_LLI: begin
        wr_en = 1'b1; wr_addr = instr[RS_MSB:RS_LSB];
        wr_data = zext9(instr[IMM9_MSB:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem_reg[i] <= '0;
      for (int i = 0; i < NUM_REGS; i++)   rf_reg[i]   <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_reg[i] <= '0;
    end else if (ena) begin
      if (prog_en) begin
        pc_reg <= '0;
        if (prog_we) begin
          if (byte_sel) imem_reg[prog_addr][15:8] <= uio_in;
          else          imem_reg[prog_addr][7:0]  <= uio_in;
        end
      end else begin
        pc_reg <= pc_next;
        // r0 is never written, so its reset value keeps it reading zero.
        if (wr_en && (wr_addr != '0)) rf_reg[wr_addr] <= wr_data;
        if (dm_we) dmem_reg[dm_addr] <= rt_val;
      end
    end
  end

  always_comb begin
    dbg_word = rf_reg[ui_in[2:0]];
    if (prog_en)       dbg_word = imem_reg[prog_addr];
    else if (ui_in[3]) dbg_word = {{(DATA_W-PC_W){1'b0}}, pc_reg};
    uo_out = byte_sel ? dbg_word[15:8] : dbg_word[7:0];
    if (!prog_en && ui_in[3]) uo_out = {4'b0000, pc_reg};
  end

endmodule

// File: tb/tb_mips16_single_cycle.sv
// Scoreboard bench for mips16_single_cycle: loads programs through the pins,
// runs them and compares debug-mux bytes against expectations queued at drive time.
module tb_mips16_single_cycle;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic [7:0] sb [$];
  logic [7:0] got;
  logic [7:0] want;
  int         total = 0;
  int         bad   = 0;

  mips16_single_cycle dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_word(input logic [3:0] addr, input logic [15:0] w);
    ena = 1'b1;
    ui_in = {4'b1010, addr}; uio_in = w[7:0];
    @(negedge clk);
    ui_in = {4'b1011, addr}; uio_in = w[15:8];
    @(negedge clk);
    ui_in = 8'h80;
  endtask

  task automatic run(input int n);
    ena = 1'b1; ui_in = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] sel [2] = '{8'h08, 8'h01};
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = sel[i];
      sb.push_back(8'h00);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL reset[%0d] ui_in=%02h got=%02h want=%02h", i, sel[i], got, want);
      end else $display("ok reset[%0d] ui_in=%02h uo_out=%02h", i, sel[i], got);
    end
    total++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      bad++; $display("FAIL uio_const got=%02h/%02h want=00/00", uio_out, uio_oe);
    end else $display("ok uio_const uio_out=%02h uio_oe=%02h", uio_out, uio_oe);
  endtask

  task automatic test_load_readback();
    logic [7:0] sel [2] = '{8'h90, 8'h80};
    logic [7:0] exp [2] = '{8'h82, 8'h05};
    load_word(4'd0, 16'h8205);
    for (int i = 0; i < 2; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = sel[i];
      sb.push_back(exp[i]);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL readback[%0d] ui_in=%02h got=%02h want=%02h", i, sel[i], got, want);
      end else $display("ok readback[%0d] ui_in=%02h uo_out=%02h", i, sel[i], got);
    end
  endtask

  task automatic test_alu();
    logic [7:0] sel [4] = '{8'h03, 8'h14, 8'h04, 8'h08};
    logic [7:0] exp [4] = '{8'h0C, 8'hFF, 8'hFE, 8'h04};
    load_word(4'd1, 16'h8407);
    load_word(4'd2, 16'h0298);
    load_word(4'd3, 16'h02A1);
    run(4);
    for (int i = 0; i < 4; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = sel[i];
      sb.push_back(exp[i]);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL alu[%0d] ui_in=%02h got=%02h want=%02h", i, sel[i], got, want);
      end else $display("ok alu[%0d] ui_in=%02h uo_out=%02h", i, sel[i], got);
    end
  endtask

  task automatic test_memory();
    logic [7:0] sel [2] = '{8'h05, 8'h08};
    logic [7:0] exp [2] = '{8'h0C, 8'h06};
    load_word(4'd4, 16'h40C2);
    load_word(4'd5, 16'h3142);
    run(6);
    for (int i = 0; i < 2; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = sel[i];
      sb.push_back(exp[i]);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL memory[%0d] ui_in=%02h got=%02h want=%02h", i, sel[i], got, want);
      end else $display("ok memory[%0d] ui_in=%02h uo_out=%02h", i, sel[i], got);
    end
  endtask

  task automatic test_branch();
    load_word(4'd6, 16'h503F);
    run(7);
    for (int i = 0; i < 4; i++) begin
      ena = 1'b1; ui_in = 8'h08;
      sb.push_back(8'h06);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL branch_hold[%0d] pc got=%02h want=%02h", i, got, want);
      end else $display("ok branch_hold[%0d] pc=%02h", i, got);
      @(negedge clk);
    end
  endtask

  task automatic test_freeze();
    load_word(4'd0, 16'h8205);
    run(2);
    for (int i = 0; i < 5; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = 8'h08;
      sb.push_back(8'h02);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL freeze[%0d] pc got=%02h want=%02h", i, got, want);
      end else $display("ok freeze[%0d] pc=%02h", i, got);
    end
  endtask

  task automatic test_alu_ext();
    logic [15:0] prog [9] = '{16'h8205, 16'h8407, 16'h029D, 16'h02A6, 16'h137A,
                              16'h2B80, 16'h6281, 16'h8EAA, 16'h0EBC};
    logic [7:0] sel [7] = '{8'h08, 8'h03, 8'h04, 8'h14, 8'h15, 8'h06, 8'h07};
    logic [7:0] exp [7] = '{8'h09, 8'h01, 8'h80, 8'h02, 8'hFF, 8'h01, 8'h07};
    reset_dut();
    for (int i = 0; i < 9; i++) load_word(i[3:0], prog[i]);
    run(8);
    for (int i = 0; i < 7; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = sel[i];
      sb.push_back(exp[i]);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL alu_ext[%0d] ui_in=%02h got=%02h want=%02h", i, sel[i], got, want);
      end else $display("ok alu_ext[%0d] ui_in=%02h uo_out=%02h", i, sel[i], got);
    end
  endtask

  task automatic test_r0_jump();
    logic [7:0] psel [2] = '{8'h91, 8'h95};
    logic [7:0] pexp [2] = '{8'h70, 8'h00};
    logic [7:0] sel [2]  = '{8'h00, 8'h08};
    logic [7:0] exp [2]  = '{8'h00, 8'h0A};
    reset_dut();
    load_word(4'd0, 16'h8011);
    load_word(4'd1, 16'h700A);
    for (int i = 0; i < 2; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = psel[i];
      sb.push_back(pexp[i]);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL imem_after_reset[%0d] ui_in=%02h got=%02h want=%02h", i, psel[i], got, want);
      end else $display("ok imem_after_reset[%0d] ui_in=%02h uo_out=%02h", i, psel[i], got);
    end
    ena = 1'b1; ui_in = 8'h80;
    @(negedge clk);
    run(2);
    for (int i = 0; i < 2; i++) begin
      ena = 1'b0;
      @(negedge clk); ui_in = sel[i];
      sb.push_back(exp[i]);
      #1; got = uo_out; want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL r0_jump[%0d] ui_in=%02h got=%02h want=%02h", i, sel[i], got, want);
      end else $display("ok r0_jump[%0d] ui_in=%02h uo_out=%02h", i, sel[i], got);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_load_readback();
    test_alu();
    test_memory();
    test_branch();
    test_freeze();
    test_alu_ext();
    test_r0_jump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
